superscalar_fifo: RTL

- Parametrised N-wide circular buffer: up to N in-order writes and up to N in-order reads per cycle, plus rollback of the tail to an earlier index.
- Generalises the single-entry FIFO behind our ROB checks.
- Shared base for ROB storage, free list and store queue; dispatch writes, retire reads, branch recovery flushes.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_ptr_wrap.sv | 21 ++
 rtl/superscalar_fifo.sv | 116 +++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared index/count types and modulo-DEPTH pointer helper
package fifo_pkg;

  localparam int unsigned FIFO_DEPTH = 32;

  typedef logic [$clog2(FIFO_DEPTH)-1:0]   idx_t;
  typedef logic [$clog2(FIFO_DEPTH+1)-1:0] cnt_t;

  // Single compare-and-subtract; callers keep idx < depth and inc <= depth.
  function automatic int unsigned wrap_add(int unsigned idx, int unsigned inc,
                                           int unsigned depth);
    int unsigned sum;
    sum = idx + inc;
    if (sum >= depth) sum = sum - depth;
    return sum;
  endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// rtl/fifo_ptr_wrap.sv - combinational modulo-DEPTH pointer adder
module fifo_ptr_wrap
  import fifo_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int IW    = $clog2(DEPTH),
  parameter int INCW  = $clog2(DEPTH+1)
) (
  input  logic [IW-1:0]   idx_i,
  input  logic [INCW-1:0] inc_i,
  output logic [IW-1:0]   sum_o
);

  int unsigned sum;

  always_comb begin
    sum   = wrap_add(32'(idx_i), 32'(inc_i), DEPTH);
    sum_o = IW'(sum);
  end

endmodule

// File: rtl/superscalar_fifo.sv
// rtl/superscalar_fifo.sv - N-wide in-order circular buffer with tail rollback
// SUPERSCALAR_FIFO_PEAK_EN adds the registered high-water mark output peak_count.
module superscalar_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32,
  parameter int N     = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [N*WIDTH-1:0]           wr_data,
  input  logic [$clog2(N+1)-1:0]       num_wr,
  input  logic [$clog2(N+1)-1:0]       num_rd,
  input  logic                         flush_en,
  input  logic [$clog2(DEPTH)-1:0]     flush_tail,
  output logic [N*WIDTH-1:0]           rd_data,
  output logic [N-1:0]                 rd_valid,
  output logic [$clog2(DEPTH+1)-1:0]   spots,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [$clog2(DEPTH)-1:0]     head_idx,
  output logic [$clog2(DEPTH)-1:0]     tail_idx,
  output logic                         full,
  output logic                         empty
`ifdef SUPERSCALAR_FIFO_PEAK_EN
  , output logic [$clog2(DEPTH+1)-1:0] peak_count
`endif
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [IW-1:0]    head_q, head_d, tail_q, tail_d, head_adv, tail_adv;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    free_w, spots_w, wr_acc, rd_acc, num_wr_w, num_rd_w, flush_keep;
  logic [IW-1:0]    wr_addr [N];
  logic [IW-1:0]    rd_addr [N];

  assign num_wr_w = CW'(num_wr);
  assign num_rd_w = CW'(num_rd);
  assign free_w   = CW'(DEPTH) - count_q;
  assign spots_w  = (free_w < CW'(N)) ? free_w : CW'(N);
  assign wr_acc   = flush_en ? '0 : ((num_wr_w < spots_w) ? num_wr_w : spots_w);
  assign rd_acc   = (num_rd_w < count_q) ? num_rd_w : count_q;

  // Entries kept by a rollback: distance from head to the new tail.
  assign flush_keep = (flush_tail >= head_q) ? CW'(flush_tail - head_q)
                                             : CW'(flush_tail) + CW'(DEPTH) - CW'(head_q);

  fifo_ptr_wrap #(.DEPTH(DEPTH)) u_head_adv (.idx_i(head_q), .inc_i(rd_acc), .sum_o(head_adv));
  fifo_ptr_wrap #(.DEPTH(DEPTH)) u_tail_adv (.idx_i(tail_q), .inc_i(wr_acc), .sum_o(tail_adv));

  for (genvar i = 0; i < N; i++) begin : g_lane
    fifo_ptr_wrap #(.DEPTH(DEPTH)) u_wr_addr (.idx_i(tail_q), .inc_i(CW'(i)), .sum_o(wr_addr[i]));
    fifo_ptr_wrap #(.DEPTH(DEPTH)) u_rd_addr (.idx_i(head_q), .inc_i(CW'(i)), .sum_o(rd_addr[i]));
    assign rd_data[i*WIDTH +: WIDTH] = mem_q[rd_addr[i]];
    assign rd_valid[i]               = CW'(i) < count_q;
  end

  always_comb begin
    head_d  = head_adv;
    tail_d  = tail_adv;
    count_d = count_q + wr_acc - rd_acc;
    if (flush_en) begin
      tail_d = flush_tail;
      if (flush_tail == head_q) begin
        head_d  = flush_tail;
        count_d = '0;
      end else begin
        count_d = flush_keep - rd_acc;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        if (CW'(i) < wr_acc) mem_q[wr_addr[i]] <= wr_data[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef SUPERSCALAR_FIFO_PEAK_EN
  logic [CW-1:0] peak_q, peak_d;

  assign peak_d = (count_d > peak_q) ? count_d : peak_q;

  always_ff @(posedge clock) begin
    if (!reset) peak_q <= '0;
    else        peak_q <= peak_d;
  end

  assign peak_count = peak_q;
`endif

  assign spots    = spots_w;
  assign count    = count_q;
  assign head_idx = head_q;
  assign tail_idx = tail_q;
  assign full     = count_q == CW'(DEPTH);
  assign empty    = count_q == '0;

endmodule
